neopx_axis_rx: RTL and testbench



---
 rtl/neopx_pkg.sv | 28 ++
 rtl/neopx_rx_sync.sv | 33 +++
 rtl/neopx_axis_rx.sv | 219 +++++++++++++++++++++
 tb/tb_neopx_axis_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/neopx_pkg.sv
// Shared definitions for the NeoPixel strip transmitter/receiver pair:
// LED type codes, pulse timing in nanoseconds, the receiver state
// encoding and the ns-to-cycles conversion used to size every counter.
package neopx_pkg;

  localparam int LED_WS2812 = 0;  // 24 bits per pixel
  localparam int LED_SK6812 = 1;  // 32 bits per pixel

  // Pulse timing in nanoseconds, common to transmit and receive sides.
  localparam int T_THRESH_WS_NS  = 600;
  localparam int T_THRESH_SK_NS  = 450;
  localparam int T_MIN_PULSE_NS  = 100;
  localparam int T_MAX_HIGH_NS   = 2000;
  localparam int T_RESET_DET_NS  = 50_000;

  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,  // waiting for a full latch gap before trusting the line
    RX_IDLE = 2'd1,  // between frames, waiting for the first rising edge
    RX_HIGH = 2'd2,  // measuring a high pulse
    RX_LOW  = 2'd3   // inside a frame, timing the low gap
  } rx_state_e;

  // Round-to-nearest conversion of a duration to clock cycles, 24-bit result.
  function automatic logic [23:0] ns_to_cyc(input int unsigned ns, input int unsigned clk_hz);
    return 24'((64'(ns) * 64'(clk_hz) + 64'd500_000_000) / 64'd1_000_000_000);
  endfunction

endpackage

// File: rtl/neopx_rx_sync.sv
// Two-flop synchronizer for the asynchronous strip line followed by a
// registered edge detector. The level output is delayed to line up with
// the edge strobes, so a pin edge shows up internally three cycles later.
module neopx_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s1;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      s1   <= 1'b0;
      s    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      s1   <= meta;
      s    <= s1;
      rise <= s1 & ~s;
      fall <= ~s1 & s;
    end
  end

endmodule

// File: rtl/neopx_axis_rx.sv
// WS2812/SK6812 one-wire stream decoder. Classifies each high pulse by
// width, assembles MSB-first pixels and presents them on an AXI-Stream
// master, marking the pixel before each latch gap with tlast.
//
// Output handshake: a beat transfers on any clock edge where
// m_axis_tvalid && m_axis_tready; while tvalid is high and tready is low,
// tdata/tlast are held unchanged and the slot is never overwritten.
module neopx_axis_rx
  import neopx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int LED_TYPE    = 0
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        i_serial,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        o_overrun,
  output logic        o_frame_err
);

  if (CLK_FREQ_HZ < 10_000_000 || CLK_FREQ_HZ > 200_000_000) begin : g_bad_clk
    $error("neopx_axis_rx: CLK_FREQ_HZ must be within 10..200 MHz");
  end

  localparam logic [23:0] THRESH    = ns_to_cyc((LED_TYPE == LED_SK6812) ?
                                                T_THRESH_SK_NS : T_THRESH_WS_NS, CLK_FREQ_HZ);
  localparam logic [23:0] MIN_PULSE = ns_to_cyc(T_MIN_PULSE_NS, CLK_FREQ_HZ);
  localparam logic [23:0] MAX_HIGH  = ns_to_cyc(T_MAX_HIGH_NS, CLK_FREQ_HZ);
  localparam logic [23:0] RESET_DET = ns_to_cyc(T_RESET_DET_NS, CLK_FREQ_HZ);
  localparam int          BITS      = (LED_TYPE == LED_SK6812) ? 32 : 24;
  localparam logic [5:0]  BITS_M1   = 6'(BITS - 1);

  logic        s, rise, fall;
  rx_state_e   state, state_nxt;
  logic [23:0] width, width_nxt, width_inc;
  logic [23:0] low_cnt, low_cnt_nxt, low_inc;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [30:0] shreg, shreg_nxt;
  logic [31:0] pend, pend_nxt, word;
  logic        pend_v, pend_v_nxt;
  logic        bit_ok, bit_val, latch, err_nxt;
  logic        xfer_req, xfer_req_last;
  logic        xfer_v, xfer_last;
  logic [31:0] xfer_data;

  neopx_rx_sync u_sync (
    .clk   (axis_aclk),
    .rst_n (axis_aresetn),
    .din   (i_serial),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  assign width_inc = (width == 24'hFF_FFFF) ? width : width + 24'd1;
  assign low_inc   = (low_cnt == 24'hFF_FFFF) ? low_cnt : low_cnt + 24'd1;

  // Next-state logic for line timing, bit assembly and pixel hand-off.
  always_comb begin
    state_nxt     = state;
    width_nxt     = width;
    low_cnt_nxt   = low_cnt;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    pend_nxt      = pend;
    pend_v_nxt    = pend_v;
    bit_ok        = 1'b0;
    bit_val       = 1'b0;
    latch         = 1'b0;
    err_nxt       = 1'b0;
    xfer_req      = 1'b0;
    xfer_req_last = 1'b0;
    word          = 32'd0;

    case (state)
      RX_SYNC: begin
        if (s) begin
          low_cnt_nxt = 24'd0;
        end else if (low_inc >= RESET_DET) begin
          low_cnt_nxt = 24'd0;
          state_nxt   = RX_IDLE;
        end else begin
          low_cnt_nxt = low_inc;
        end
      end
      RX_IDLE: begin
        if (rise) begin
          width_nxt = 24'd0;
          state_nxt = RX_HIGH;
        end
      end
      RX_HIGH: begin
        if (fall) begin
          low_cnt_nxt = 24'd0;
          if (width < MIN_PULSE) begin
            // Too short to be a bit: treat as line noise.
            state_nxt = (bit_cnt == 6'd0 && !pend_v) ? RX_IDLE : RX_LOW;
          end else begin
            bit_ok    = 1'b1;
            bit_val   = (width >= THRESH);
            state_nxt = RX_LOW;
          end
        end else if (width > MAX_HIGH) begin
          // Stuck-high line: throw away everything not yet handed off.
          err_nxt     = 1'b1;
          bit_cnt_nxt = 6'd0;
          pend_v_nxt  = 1'b0;
          low_cnt_nxt = 24'd0;
          state_nxt   = RX_SYNC;
        end else begin
          width_nxt = width_inc;
        end
      end
      RX_LOW: begin
        if (rise) begin
          width_nxt = 24'd0;
          state_nxt = RX_HIGH;
        end else if (low_inc >= RESET_DET) begin
          latch       = 1'b1;
          low_cnt_nxt = 24'd0;
          state_nxt   = RX_IDLE;
        end else begin
          low_cnt_nxt = low_inc;
        end
      end
      default: state_nxt = RX_SYNC;
    endcase

    // A new bit proves the pending pixel was not the last of the frame.
    if (bit_ok) begin
      if (pend_v) begin
        xfer_req   = 1'b1;
        pend_v_nxt = 1'b0;
      end
      word = (BITS == 32) ? {shreg, bit_val} : {shreg[22:0], bit_val, 8'h00};
      if (bit_cnt == BITS_M1) begin
        pend_nxt    = word;
        pend_v_nxt  = 1'b1;
        bit_cnt_nxt = 6'd0;
      end else begin
        shreg_nxt   = {shreg[29:0], bit_val};
        bit_cnt_nxt = bit_cnt + 6'd1;
      end
    end

    // Latch gap: the pending pixel closes the frame; leftover bits are an error.
    if (latch) begin
      if (pend_v) begin
        xfer_req      = 1'b1;
        xfer_req_last = 1'b1;
        pend_v_nxt    = 1'b0;
      end
      if (bit_cnt != 6'd0) begin
        err_nxt     = 1'b1;
        bit_cnt_nxt = 6'd0;
      end
    end
  end

  // Receiver state, counters, pending pixel and transfer staging.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state       <= RX_SYNC;
      width       <= 24'd0;
      low_cnt     <= 24'd0;
      bit_cnt     <= 6'd0;
      shreg       <= 31'd0;
      pend        <= 32'd0;
      pend_v      <= 1'b0;
      xfer_v      <= 1'b0;
      xfer_last   <= 1'b0;
      xfer_data   <= 32'd0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      width       <= width_nxt;
      low_cnt     <= low_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      pend        <= pend_nxt;
      pend_v      <= pend_v_nxt;
      xfer_v      <= xfer_req;
      xfer_last   <= xfer_req_last;
      xfer_data   <= pend;
      o_frame_err <= err_nxt;
    end
  end

  // Output slot: accept, then load a staged pixel unless the slot is blocked.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tdata  <= 32'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= 32'd0;
        m_axis_tlast  <= 1'b0;
      end
      if (xfer_v) begin
        if (m_axis_tvalid && !m_axis_tready) begin
          o_overrun <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= xfer_data;
          m_axis_tlast  <= xfer_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_neopx_axis_rx.sv
// Directed bench for neopx_axis_rx at 72 MHz. Drives transmitter-accurate
// NRZ waveforms (T0H 29, T1H 58, 90-cycle bit period) into a WS2812 and an
// SK6812 receiver sharing one line, and checks beats, tlast and pulses.
`timescale 1ns/1ps
module tb_neopx_axis_rx;

  localparam int LATCH_CYC = 3650;

  logic        clk;
  logic        rst_n;
  logic        serial;
  logic        ws_ready, sk_ready;
  logic [31:0] ws_tdata, sk_tdata;
  logic        ws_tvalid, ws_tlast, ws_ovr, ws_ferr;
  logic        sk_tvalid, sk_tlast, sk_ovr, sk_ferr;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [32:0] exp_q[$];
  int          ws_beats = 0, ws_ferr_cnt = 0, ws_ovr_cnt = 0;
  int          sk_beats = 0, sk_ferr_cnt = 0;
  logic [32:0] sk_last_beat = '0;

  neopx_axis_rx #(.CLK_FREQ_HZ(72_000_000), .LED_TYPE(0)) u_ws (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .i_serial      (serial),
    .m_axis_tdata  (ws_tdata),
    .m_axis_tvalid (ws_tvalid),
    .m_axis_tlast  (ws_tlast),
    .m_axis_tready (ws_ready),
    .o_overrun     (ws_ovr),
    .o_frame_err   (ws_ferr)
  );

  neopx_axis_rx #(.CLK_FREQ_HZ(72_000_000), .LED_TYPE(1)) u_sk (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .i_serial      (serial),
    .m_axis_tdata  (sk_tdata),
    .m_axis_tvalid (sk_tvalid),
    .m_axis_tlast  (sk_tlast),
    .m_axis_tready (sk_ready),
    .o_overrun     (sk_ovr),
    .o_frame_err   (sk_ferr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #7 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    check(tag, 33'(obs), 33'(exp));
  endtask

  // Driver tasks (inputs change on the falling edge)
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    serial = 1'b1;
    wait_cyc(b ? 58 : 29);
    serial = 1'b0;
    if (glitch) begin
      wait_cyc(12);
      serial = 1'b1;
      wait_cyc(4);
      serial = 1'b0;
      wait_cyc((b ? 32 : 61) - 16);
    end else begin
      wait_cyc(b ? 32 : 61);
    end
  endtask

  task automatic send_px(input logic [31:0] px, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) send_bit(px[31-i], i == glitch_at);
  endtask

  task automatic latch_gap();
    serial = 1'b0;
    wait_cyc(LATCH_CYC);
  endtask

  // Scoreboard/monitor, sampled well away from the active edge
  always @(negedge clk) begin
    #1;
    if (ws_ferr) ws_ferr_cnt++;
    if (ws_ovr)  ws_ovr_cnt++;
    if (sk_ferr) sk_ferr_cnt++;
    if (sk_tvalid && sk_ready) begin
      sk_beats++;
      sk_last_beat = {sk_tlast, sk_tdata};
    end
    if (ws_tvalid && ws_ready) begin
      ws_beats++;
      if (exp_q.size() > 0) check("ws_beat", {ws_tlast, ws_tdata}, exp_q.pop_front());
      else                  check("ws_unexpected_beat", {ws_tlast, ws_tdata}, {1'b1, 32'hDEAD_BEEF});
    end
  end

  int b0, f0, o0, sb0, sf0;

  task automatic snap();
    b0 = ws_beats; f0 = ws_ferr_cnt; o0 = ws_ovr_cnt; sb0 = sk_beats; sf0 = sk_ferr_cnt;
  endtask

  initial begin
    serial = 1'b0; ws_ready = 1'b1; sk_ready = 1'b1; rst_n = 1'b0;
    wait_cyc(4);
    check("rst_ws_flags", 33'({ws_tvalid, ws_tlast, ws_ovr, ws_ferr}), 33'd0);
    check("rst_ws_tdata", 33'(ws_tdata), 33'd0);
    check("rst_sk_flags", 33'({sk_tvalid, sk_tlast, sk_ovr, sk_ferr}), 33'd0);
    rst_n = 1'b1;
    latch_gap();

    // Single WS2812 pixel closed by a latch gap
    snap();
    exp_q.push_back({1'b1, 32'h1234_5600});
    send_px(32'h1234_5600, 24, -1);
    latch_gap();
    check_cnt("t1_beats", ws_beats - b0, 1);
    check_cnt("t1_ferr", ws_ferr_cnt - f0, 0);
    check_cnt("t1_ovr", ws_ovr_cnt - o0, 0);
    check_cnt("t1_q_empty", exp_q.size(), 0);

    // Two pixels separated by a short gap: only the second carries tlast
    snap();
    exp_q.push_back({1'b0, 32'hFF00_0000});
    exp_q.push_back({1'b1, 32'h00FF_0000});
    send_px(32'hFF00_0000, 24, -1);
    wait_cyc(15);
    send_px(32'h00FF_0000, 24, -1);
    latch_gap();
    check_cnt("t2_beats", ws_beats - b0, 2);
    check_cnt("t2_ferr", ws_ferr_cnt - f0, 0);
    check_cnt("t2_q_empty", exp_q.size(), 0);

    // SK6812 pixel with a 4-cycle glitch inside the low of bit 5;
    // the WS2812 receiver sees 24 bits + 8 leftover bits on the same line
    snap();
    exp_q.push_back({1'b0, 32'hA5C3_F000});
    send_px(32'hA5C3_F00F, 32, 5);
    latch_gap();
    check_cnt("t3_sk_beats", sk_beats - sb0, 1);
    check("t3_sk_beat", sk_last_beat, {1'b1, 32'hA5C3_F00F});
    check_cnt("t3_sk_ferr", sk_ferr_cnt - sf0, 0);
    check_cnt("t3_ws_ferr", ws_ferr_cnt - f0, 1);
    check_cnt("t3_q_empty", exp_q.size(), 0);

    // Stalled sink across three pixels and a latch
    snap();
    ws_ready = 1'b0;
    send_px(32'h1111_1100, 24, -1);
    send_px(32'h2222_2200, 24, -1);
    check("t4_hold_a", {ws_tlast, ws_tdata}, {1'b0, 32'h1111_1100});
    check("t4_valid_a", 33'(ws_tvalid), 33'd1);
    send_px(32'h3333_3300, 24, -1);
    latch_gap();
    check("t4_hold_b", {ws_tlast, ws_tdata}, {1'b0, 32'h1111_1100});
    check_cnt("t4_ovr", ws_ovr_cnt - o0, 2);
    exp_q.push_back({1'b0, 32'h1111_1100});
    ws_ready = 1'b1;
    wait_cyc(10);
    check_cnt("t4_beats", ws_beats - b0, 1);
    check_cnt("t4_q_empty", exp_q.size(), 0);
    check("t4_valid_after", 33'(ws_tvalid), 33'd0);

    // Partial pixel at latch, then an over-long high forcing resync
    snap();
    send_px(32'hFFC0_0000, 10, -1);
    latch_gap();
    check_cnt("t5_partial_ferr", ws_ferr_cnt - f0, 1);
    check_cnt("t5_partial_beats", ws_beats - b0, 0);
    serial = 1'b1;
    wait_cyc(216);
    serial = 1'b0;
    wait_cyc(40);
    check_cnt("t5_longhigh_ferr", ws_ferr_cnt - f0, 2);
    send_px(32'h7777_7700, 24, -1);
    latch_gap();
    check_cnt("t5_ignored_beats", ws_beats - b0, 0);
    exp_q.push_back({1'b1, 32'h3C3C_3C00});
    send_px(32'h3C3C_3C00, 24, -1);
    latch_gap();
    check_cnt("t5_resync_beats", ws_beats - b0, 1);
    check_cnt("t5_ferr_total", ws_ferr_cnt - f0, 2);
    check_cnt("t5_q_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a pixel
    ws_ready = 1'b0;
    send_px(32'hABCD_EF00, 24, -1);
    send_px(32'h5A5A_5A00, 5, -1);
    check("t6_valid_pre", 33'(ws_tvalid), 33'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_flags", 33'({ws_tvalid, ws_tlast, ws_ovr, ws_ferr}), 33'd0);
    check("t6_rst_tdata", 33'(ws_tdata), 33'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    ws_ready = 1'b1;
    snap();
    send_px(32'h5A5A_5A00, 24, -1);
    latch_gap();
    check_cnt("t6_ignored_beats", ws_beats - b0, 0);
    exp_q.push_back({1'b1, 32'hC0FF_EE00});
    send_px(32'hC0FF_EE00, 24, -1);
    latch_gap();
    check_cnt("t6_beats", ws_beats - b0, 1);
    check_cnt("t6_ferr", ws_ferr_cnt - f0, 0);
    check_cnt("t6_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
